// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase: divides the prescaler wrap pulse down to seconds and
// keeps an MM:SS BCD time under start/stop and clear buttons.
// Ports:
//   clk, reset      - system clock, asynchronous active-high reset
//   tick            - one-cycle timebase pulse from the prescale counter
//   btn_ss, btn_clr - raw, asynchronous start/stop and clear button levels
//   sec_ones, sec_tens, min_ones, min_tens - registered BCD time digits
//   running, paused - registered state decodes
//   wrap            - one-cycle pulse on the 59:59 -> 00:00 rollover
module stopwatch_timebase #(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned FRAC_W        = $clog2(TICKS_PER_SEC)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_ss,
    input  logic       btn_clr,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       paused,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [2:0]        ss_sync, clr_sync;
    logic              ss_edge, clr_edge;
    logic              clear, count_en, frac_last;
    logic [FRAC_W-1:0] frac, frac_next;
    logic [3:0]        sec_ones_next, sec_tens_next, min_ones_next, min_tens_next;
    logic              wrap_next;

    // Two-flop synchronizers plus a third flop for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_sync  <= 3'b000;
            clr_sync <= 3'b000;
        end else begin
            ss_sync  <= {ss_sync[1:0], btn_ss};
            clr_sync <= {clr_sync[1:0], btn_clr};
        end
    end

    assign ss_edge  = ss_sync[1] & ~ss_sync[2];
    assign clr_edge = clr_sync[1] & ~clr_sync[2];

    // State register and registered state decodes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            paused  <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            paused  <= (state_next == PAUSE);
        end
    end

    // Next-state logic; start/stop has priority over clear
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_edge)       state_next = RUN;
                else if (clr_edge) clear = 1'b1;
            end
            RUN: begin
                if (ss_edge) state_next = PAUSE;
            end
            PAUSE: begin
                if (ss_edge) begin
                    state_next = RUN;
                end else if (clr_edge) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counting qualifies on the pre-edge state, so a tick on RUN->PAUSE counts
    assign count_en  = tick && (state == RUN);
    assign frac_last = (frac == FRAC_W'(TICKS_PER_SEC - 1));

    // Sub-second counter and BCD digit cascade
    always_comb begin
        frac_next     = frac;
        sec_ones_next = sec_ones;
        sec_tens_next = sec_tens;
        min_ones_next = min_ones;
        min_tens_next = min_tens;
        wrap_next     = 1'b0;
        if (clear) begin
            frac_next     = '0;
            sec_ones_next = 4'd0;
            sec_tens_next = 4'd0;
            min_ones_next = 4'd0;
            min_tens_next = 4'd0;
        end else if (count_en) begin
            if (!frac_last) begin
                frac_next = frac + FRAC_W'(1);
            end else begin
                frac_next = '0;
                if (sec_ones != 4'd9) begin
                    sec_ones_next = sec_ones + 4'd1;
                end else begin
                    sec_ones_next = 4'd0;
                    if (sec_tens != 4'd5) begin
                        sec_tens_next = sec_tens + 4'd1;
                    end else begin
                        sec_tens_next = 4'd0;
                        if (min_ones != 4'd9) begin
                            min_ones_next = min_ones + 4'd1;
                        end else begin
                            min_ones_next = 4'd0;
                            if (min_tens != 4'd5) begin
                                min_tens_next = min_tens + 4'd1;
                            end else begin
                                min_tens_next = 4'd0;
                                wrap_next     = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Time registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frac     <= '0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            wrap     <= 1'b0;
        end else begin
            frac     <= frac_next;
            sec_ones <= sec_ones_next;
            sec_tens <= sec_tens_next;
            min_ones <= min_ones_next;
            min_tens <= min_tens_next;
            wrap     <= wrap_next;
        end
    end

endmodule
